// File: rtl/count_event_fifo_if.sv
// Event record handshake between count_event_fifo and its consumer.
// The FIFO drives the master side; the scoreboard/host drives evt_ready.
interface count_event_fifo_if #(
  parameter int WIDTH = 32
);
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_type;
  logic [WIDTH-1:0] evt_value;

  modport master (output evt_valid, evt_type, evt_value, input evt_ready);
  modport slave  (input evt_valid, evt_type, evt_value, output evt_ready);
endinterface

// File: rtl/count_event_fifo.sv
// Classifies transitions of a sampled counter value (wrap, jump, threshold hit)
// and queues one record per cycle in a first-word-fall-through FIFO with drop accounting.
module count_event_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           count_in,
  input  logic [WIDTH-1:0]           thresh,
  count_event_fifo_if.master         evt,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {WRAP_UP, WRAP_DN, JUMP, THRESH} evt_type_e;

  logic [WIDTH-1:0] prev_q;
  logic             prev_valid;
  logic [1:0]       type_mem  [DEPTH];
  logic [WIDTH-1:0] value_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic      hit;
  evt_type_e kind;
  logic      empty;
  logic      full;
  logic      push_req;
  logic      push_ok;
  logic      pop;
  logic      drop;

  // Priority chain: a lower-priority match in the same cycle is simply discarded.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    hit  = 1'b0;
    kind = WRAP_UP;
    if (prev_q == '1 && count_in == '0) begin
      hit  = 1'b1;
      kind = WRAP_UP;
    end else if (prev_q == '0 && count_in == '1) begin
      hit  = 1'b1;
      kind = WRAP_DN;
    end else if (count_in != prev_q && count_in != prev_q + WIDTH'(1) &&
                 count_in != prev_q - WIDTH'(1)) begin
      hit  = 1'b1;
      kind = JUMP;
    end else if (count_in == thresh && prev_q != thresh) begin
      hit  = 1'b1;
      kind = THRESH;
    end
  end

  assign empty    = (fifo_level == '0);
  assign full     = (fifo_level == LW'(DEPTH));
  assign push_req = en && !clear && prev_valid && hit;
  assign pop      = !empty && evt.evt_ready && !clear;
  // A pop frees the slot in the same edge, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign evt.evt_valid = !empty;
  assign evt.evt_type  = empty ? 2'b00 : type_mem[rd_ptr];
  assign evt.evt_value = empty ? '0 : value_mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked by the level
  // counter, so stale entries are never visible.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      type_mem[wr_ptr]  <= kind;
      value_mem[wr_ptr] <= count_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      prev_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      prev_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (en) begin
        prev_q     <= count_in;
        prev_valid <= 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_event_fifo.sv
// Directed bench for count_event_fifo: a queue-based reference model checked every
// cycle, plus literal expectations that pin the model on each scenario.
module tb_count_event_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int DROP_W = 16;
  localparam logic [31:0] NO_TH = 32'hFFFF_0000;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic              clear = 1'b0;
  logic [WIDTH-1:0]  count_in = '0;
  logic [WIDTH-1:0]  thresh = '0;
  logic [3:0]        fifo_level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  count_event_fifo_if #(.WIDTH(WIDTH)) evt_bus ();

  count_event_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .clear      (clear),
    .count_in   (count_in),
    .thresh     (thresh),
    .evt        (evt_bus),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: records as a queue, classification by modular difference.
  typedef struct packed { logic [1:0] kind; logic [31:0] value; } rec_t;
  rec_t        mq[$];
  logic [31:0] m_prev = '0;
  bit          m_pv = 0;
  bit          m_ov = 0;
  int          m_dc = 0;

  function automatic bit classify(input logic [31:0] prev, cur, th, output logic [1:0] kind);
    logic [31:0] diff;
    diff = cur - prev;
    kind = 2'd0;
    if (prev == 32'hFFFF_FFFF && cur == 32'h0) begin kind = 2'd0; return 1; end
    if (prev == 32'h0 && cur == 32'hFFFF_FFFF) begin kind = 2'd1; return 1; end
    if (diff != 32'd0 && diff != 32'd1 && diff != 32'hFFFF_FFFF) begin kind = 2'd2; return 1; end
    if (cur == th && prev != th) begin kind = 2'd3; return 1; end
    return 0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete(); m_pv = 0; m_ov = 0; m_dc = 0; m_prev = '0;
    end else if (clear) begin
      mq.delete(); m_pv = 0; m_ov = 0; m_dc = 0;
    end else begin
      logic [1:0] k;
      bit got;
      got = en && m_pv && classify(m_prev, count_in, thresh, k);
      if (mq.size() > 0 && evt_bus.evt_ready) void'(mq.pop_front());
      if (got) begin
        if (mq.size() < DEPTH) mq.push_back('{kind: k, value: count_in});
        else begin
          m_ov = 1;
          if (m_dc < 65535) m_dc++;
        end
      end
      if (en) begin m_prev = count_in; m_pv = 1; end
    end
  end

  always @(negedge clock) begin
    check("m_valid", 64'(evt_bus.evt_valid), 64'(mq.size() != 0));
    check("m_level", 64'(fifo_level), 64'(mq.size()));
    check("m_overflow", 64'(overflow), 64'(m_ov));
    check("m_drop", 64'(drop_count), 64'(m_dc));
    if (mq.size() != 0) begin
      check("m_type", 64'(evt_bus.evt_type), 64'(mq[0].kind));
      check("m_value", 64'(evt_bus.evt_value), 64'(mq[0].value));
    end
  end

  task automatic step(input logic e, c, input logic [31:0] cnt, th, input logic r);
    en = e; clear = c; count_in = cnt; thresh = th; evt_bus.evt_ready = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    evt_bus.evt_ready = 1'b0;
    step(0, 0, 0, NO_TH, 0);
    step(0, 0, 0, NO_TH, 0);
    check("rst_valid", 64'(evt_bus.evt_valid), 64'd0);
    check("rst_type", 64'(evt_bus.evt_type), 64'd0);
    check("rst_value", 64'(evt_bus.evt_value), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b1;

    // 1: three records queued, then asynchronous reset mid-cycle
    step(1, 0, 32'd0, NO_TH, 0);
    check("t1_first_sample", 64'(evt_bus.evt_valid), 64'd0);
    step(1, 0, 32'd100, NO_TH, 0);
    step(1, 0, 32'd5, NO_TH, 0);
    step(1, 0, 32'd50, NO_TH, 0);
    check("t1_level3", 64'(fifo_level), 64'd3);
    #2 reset = 1'b0;
    #1;
    check("t1_async_valid", 64'(evt_bus.evt_valid), 64'd0);
    check("t1_async_level", 64'(fifo_level), 64'd0);
    check("t1_async_ovf", 64'(overflow), 64'd0);
    check("t1_async_drop", 64'(drop_count), 64'd0);
    reset = 1'b1;
    step(1, 0, 32'd777, NO_TH, 0);
    check("t1_post_rst_sample", 64'(evt_bus.evt_valid), 64'd0);

    // 2: up-count across wrap
    step(1, 1, 0, 32'd5, 1);
    step(1, 0, 32'hFFFF_FFFE, 32'd5, 1);
    step(1, 0, 32'hFFFF_FFFF, 32'd5, 1);
    check("t2_no_evt", 64'(evt_bus.evt_valid), 64'd0);
    step(1, 0, 32'h0, 32'd5, 1);
    check("t2_valid", 64'(evt_bus.evt_valid), 64'd1);
    check("t2_type", 64'(evt_bus.evt_type), 64'd0);
    check("t2_value", 64'(evt_bus.evt_value), 64'd0);
    step(1, 0, 32'h1, 32'd5, 1);
    check("t2_popped", 64'(evt_bus.evt_valid), 64'd0);

    // 3: down-count across wrap with threshold at all-ones
    step(1, 1, 0, 32'hFFFF_FFFF, 1);
    step(1, 0, 32'h1, 32'hFFFF_FFFF, 1);
    step(1, 0, 32'h0, 32'hFFFF_FFFF, 1);
    step(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    check("t3_type", 64'(evt_bus.evt_type), 64'd1);
    check("t3_value", 64'(evt_bus.evt_value), 64'hFFFF_FFFF);
    check("t3_level", 64'(fifo_level), 64'd1);
    check("t3_drop", 64'(drop_count), 64'd0);
    step(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    check("t3_hold_no_thresh", 64'(evt_bus.evt_valid), 64'd0);

    // 4: load jump onto the threshold, then hold
    step(1, 1, 0, 32'h1234_5678, 0);
    step(1, 0, 32'h10, 32'h1234_5678, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 32'h1234_5678, 32'h1234_5678, 0);
    check("t4_level", 64'(fifo_level), 64'd1);
    check("t4_type", 64'(evt_bus.evt_type), 64'd2);
    check("t4_value", 64'(evt_bus.evt_value), 64'h1234_5678);
    step(1, 0, 32'h1234_5678, 32'h1234_5678, 1);
    check("t4_drained", 64'(fifo_level), 64'd0);

    // 5: overflow with 10 jumps into 8 slots, then stalled drain
    step(1, 1, 0, NO_TH, 0);
    step(1, 0, 32'd50, NO_TH, 0);
    for (int i = 0; i < 10; i++) step(1, 0, (i % 2 == 0) ? 32'd0 : 32'd100, NO_TH, 0);
    check("t5_level", 64'(fifo_level), 64'd8);
    check("t5_ovf", 64'(overflow), 64'd1);
    check("t5_drop", 64'(drop_count), 64'd2);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] want;
      want = (i % 2 == 0) ? 32'd0 : 32'd100;
      check("t5_head", 64'(evt_bus.evt_value), 64'(want));
      step(0, 0, 32'd0, NO_TH, 0);
      check("t5_stall", 64'(evt_bus.evt_value), 64'(want));
      step(0, 0, 32'd0, NO_TH, 1);
    end
    check("t5_empty", 64'(fifo_level), 64'd0);
    check("t5_ovf_sticky", 64'(overflow), 64'd1);

    // 6: full FIFO push+pop same cycle, then clear with a concurrent push
    for (int i = 0; i < 8; i++) step(1, 0, (i % 2 == 0) ? 32'd0 : 32'd100, NO_TH, 0);
    check("t6_full", 64'(fifo_level), 64'd8);
    step(1, 0, 32'd0, NO_TH, 1);
    check("t6_level_same", 64'(fifo_level), 64'd8);
    check("t6_drop_same", 64'(drop_count), 64'd2);
    check("t6_new_head", 64'(evt_bus.evt_value), 64'd100);
    step(1, 1, 32'd555, NO_TH, 1);
    check("t6_clr_level", 64'(fifo_level), 64'd0);
    check("t6_clr_ovf", 64'(overflow), 64'd0);
    check("t6_clr_drop", 64'(drop_count), 64'd0);
    check("t6_clr_valid", 64'(evt_bus.evt_valid), 64'd0);
    step(1, 0, 32'd999, NO_TH, 1);
    check("t6_first_after_clr", 64'(evt_bus.evt_valid), 64'd0);

    step(0, 0, 0, NO_TH, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
